// File: rtl/cte_color_engine.sv
// Colour transform engine: packed 24-bit RGB <-> 8-bit YUV 4:2:2 byte stream.
// op_mode=1 turns pixel pairs into U0,Y0,V0,Y1; op_mode=0 turns U,Y0,V,Y1 into two pixels.
module cte_color_engine #(
    parameter int FRAC = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_mode,
    input  logic        in_en,
    input  logic [23:0] rgb_in,
    input  logic [7:0]  yuv_in,
    output logic        busy,
    output logic        out_valid,
    output logic [23:0] rgb_out,
    output logic [7:0]  yuv_out
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIRST,
        ST_SECOND
    } stage_t;

    localparam logic signed [23:0] ROUND = 24'sd1 <<< (FRAC - 1);

    logic        r_busy;
    logic        r_valid;
    logic        r_mode;
    logic        r_emitU;
    logic [1:0]  r_phase;
    stage_t      r_stage;
    logic [7:0]  r_y;
    logic [7:0]  r_u;
    logic [7:0]  r_v;
    logic [7:0]  r_yuv;
    logic [23:0] r_rgb;

    function automatic logic [7:0] satUnsigned(input logic signed [23:0] acc);
        logic signed [23:0] s;
        s = (acc + ROUND) >>> FRAC;
        if (s < 24'sd0)
            return 8'h00;
        else if (s > 24'sd255)
            return 8'hFF;
        else
            return s[7:0];
    endfunction

    function automatic logic [7:0] satSigned(input logic signed [23:0] acc);
        logic signed [23:0] s;
        s = (acc + ROUND) >>> FRAC;
        if (s < -24'sd128)
            return 8'h80;
        else if (s > 24'sd127)
            return 8'h7F;
        else
            return s[7:0];
    endfunction

    logic               w_accept;
    logic               w_mode;
    logic signed [23:0] w_r;
    logic signed [23:0] w_g;
    logic signed [23:0] w_b;
    logic signed [23:0] w_accY;
    logic signed [23:0] w_accU;
    logic signed [23:0] w_accV;
    logic [7:0]         w_cy8;
    logic [7:0]         w_cv8;
    logic signed [23:0] w_cy;
    logic signed [23:0] w_cu;
    logic signed [23:0] w_cv;
    logic signed [23:0] w_accR;
    logic signed [23:0] w_accG;
    logic signed [23:0] w_accB;
    logic [23:0]        w_rgb;

    // The mode is only re-sampled at a pair boundary; mid-pair the stored mode rules.
    assign w_accept = in_en && !r_busy;
    assign w_mode   = (r_phase == 2'd0) ? op_mode : r_mode;

    assign w_r    = {16'd0, rgb_in[23:16]};
    assign w_g    = {16'd0, rgb_in[15:8]};
    assign w_b    = {16'd0, rgb_in[7:0]};
    assign w_accY = 24'sd1225 * w_r + 24'sd2404 * w_g + 24'sd467 * w_b;
    assign w_accU = 24'sd2048 * w_b - 24'sd692 * w_r - 24'sd1356 * w_g;
    assign w_accV = 24'sd2048 * w_r - 24'sd1716 * w_g - 24'sd332 * w_b;

    // Phase 2 (V arriving) pairs with the stored Y0; phase 3 uses the incoming Y1 and stored V.
    assign w_cy8  = (r_phase == 2'd2) ? r_y : yuv_in;
    assign w_cv8  = (r_phase == 2'd2) ? yuv_in : r_v;
    assign w_cy   = {16'd0, w_cy8};
    assign w_cu   = {{16{r_u[7]}}, r_u};
    assign w_cv   = {{16{w_cv8[7]}}, w_cv8};
    assign w_accR = (w_cy <<< FRAC) + 24'sd5743 * w_cv;
    assign w_accG = (w_cy <<< FRAC) - 24'sd1409 * w_cu - 24'sd2925 * w_cv;
    assign w_accB = (w_cy <<< FRAC) + 24'sd7258 * w_cu;
    assign w_rgb  = {satUnsigned(w_accR), satUnsigned(w_accG), satUnsigned(w_accB)};

    // Pending RGB->YUV bytes drain first; a new accept in the same cycle only loads fresh state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_mode  <= 1'b0;
            r_emitU <= 1'b0;
            r_phase <= 2'd0;
            r_stage <= ST_IDLE;
            r_y     <= 8'd0;
            r_u     <= 8'd0;
            r_v     <= 8'd0;
            r_yuv   <= 8'd0;
            r_rgb   <= 24'd0;
        end else begin
            r_valid <= 1'b0;
            case (r_stage)
                ST_FIRST: begin
                    r_yuv   <= r_emitU ? r_u : r_v;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_stage <= ST_SECOND;
                end
                ST_SECOND: begin
                    r_yuv   <= r_y;
                    r_valid <= 1'b1;
                    r_stage <= ST_IDLE;
                end
                default: ;
            endcase

            if (w_accept) begin
                if (r_phase == 2'd0)
                    r_mode <= op_mode;
                if (w_mode) begin
                    r_y     <= satUnsigned(w_accY);
                    r_emitU <= (r_phase == 2'd0);
                    if (r_phase == 2'd0) begin
                        r_u <= satSigned(w_accU);
                        r_v <= satSigned(w_accV);
                    end
                    r_phase <= (r_phase == 2'd0) ? 2'd1 : 2'd0;
                    r_busy  <= 1'b1;
                    r_stage <= ST_FIRST;
                end else begin
                    case (r_phase)
                        2'd0: r_u <= yuv_in;
                        2'd1: r_y <= yuv_in;
                        2'd2: begin
                            r_v     <= yuv_in;
                            r_rgb   <= w_rgb;
                            r_valid <= 1'b1;
                        end
                        default: begin
                            r_rgb   <= w_rgb;
                            r_valid <= 1'b1;
                        end
                    endcase
                    r_phase <= r_phase + 2'd1;
                end
            end
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_valid;
    assign rgb_out   = r_rgb;
    assign yuv_out   = r_yuv;

endmodule

// File: tb/tb_cte_color_engine.sv
// Scoreboard bench for cte_color_engine: the driver pushes expected outputs from a
// real-valued colour model, and a negedge monitor pops and compares each valid output.
module tb_cte_color_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        opMode;
    logic        inEn;
    logic [23:0] rgbIn;
    logic [7:0]  yuvIn;
    logic        busy;
    logic        outValid;
    logic [23:0] rgbOut;
    logic [7:0]  yuvOut;

    cte_color_engine #(.FRAC(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .op_mode   (opMode),
        .in_en     (inEn),
        .rgb_in    (rgbIn),
        .yuv_in    (yuvIn),
        .busy      (busy),
        .out_valid (outValid),
        .rgb_out   (rgbOut),
        .yuv_out   (yuvOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          isRgb;
        logic [23:0] val;
        bit          sgn;
        int          tol;
    } expT;

    expT sbQ[$];
    int  checks   = 0;
    int  errors   = 0;
    int  monCount = 0;
    int  mPhase   = 0;
    int  mV       = 0;
    int  gIdx     = 0;
    int  mU       = 0;
    int  mY0      = 0;
    int  mVv      = 0;
    int  startCount;

    task automatic checkOutput(input string name, input logic [23:0] act,
                               input logic [23:0] exp, input bit ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s: got %06h expected %06h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rndClamp(input real x, input int lo, input int hi);
        int r;
        r = $rtoi($floor(x + 0.5));
        if (r < lo) r = lo;
        if (r > hi) r = hi;
        return r;
    endfunction

    function automatic int toSigned8(input logic [7:0] b);
        return int'($signed(b));
    endfunction

    function automatic bit close(input int a, input int e, input int tol);
        int d;
        d = a - e;
        if (d < 0) d = -d;
        return d <= tol;
    endfunction

    function automatic logic [23:0] yuvToRgb(input int y, input int u, input int v);
        int r, g, b;
        r = rndClamp(y + 5743.0 * v / 4096.0, 0, 255);
        g = rndClamp(y - (1409.0 * u + 2925.0 * v) / 4096.0, 0, 255);
        b = rndClamp(y + 7258.0 * u / 4096.0, 0, 255);
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    task automatic pushByte(input int v, input bit sgn, input int tol);
        expT e;
        e.isRgb = 1'b0;
        e.val   = {16'd0, 8'(v)};
        e.sgn   = sgn;
        e.tol   = tol;
        sbQ.push_back(e);
    endtask

    task automatic pushRgb(input logic [23:0] v, input int tol);
        expT e;
        e.isRgb = 1'b1;
        e.val   = v;
        e.sgn   = 1'b0;
        e.tol   = tol;
        sbQ.push_back(e);
    endtask

    // Called at a negedge with the engine ready; returns one cycle after the busy cycle.
    task automatic applyPixel(input logic [23:0] p, input bit exact,
                              input logic [7:0] e0, input logic [7:0] e1);
        int r, g, b, y, u, v;
        checkOutput("busyIdle", {23'd0, busy}, 24'd0, busy === 1'b0);
        rgbIn  = p;
        opMode = 1'b1;
        inEn   = 1'b1;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
        y = rndClamp((1225.0 * r + 2404.0 * g + 467.0 * b) / 4096.0, 0, 255);
        u = rndClamp((-692.0 * r - 1356.0 * g + 2048.0 * b) / 4096.0, -128, 127);
        v = rndClamp((2048.0 * r - 1716.0 * g - 332.0 * b) / 4096.0, -128, 127);
        if (exact) begin
            pushByte(int'(e0), 1'b0, 0);
            pushByte(int'(e1), 1'b0, 0);
        end else if (mPhase == 0) begin
            pushByte(u, 1'b1, 1);
            pushByte(y, 1'b0, 1);
        end else begin
            pushByte(mV, 1'b1, 1);
            pushByte(y, 1'b0, 1);
        end
        if (mPhase == 0) mV = v;
        mPhase = 1 - mPhase;
        @(negedge clk);
        checkOutput("busyAfterAccept", {23'd0, busy}, 24'd1, busy === 1'b1);
        @(negedge clk);
    endtask

    task automatic applyByte(input logic [7:0] bt, input bit exact, input logic [23:0] expRgb);
        checkOutput("busyY2R", {23'd0, busy}, 24'd0, busy === 1'b0);
        opMode = 1'b0;
        inEn   = 1'b1;
        yuvIn  = bt;
        case (gIdx)
            0: mU = toSigned8(bt);
            1: mY0 = int'(bt);
            2: begin
                mVv = toSigned8(bt);
                pushRgb(exact ? expRgb : yuvToRgb(mY0, mU, mVv), exact ? 0 : 1);
            end
            default: pushRgb(exact ? expRgb : yuvToRgb(int'(bt), mU, mVv), exact ? 0 : 1);
        endcase
        gIdx = (gIdx + 1) % 4;
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        inEn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sbQ.size() == 0) break;
        end
        checkOutput(name, 24'(sbQ.size()), 24'd0, sbQ.size() == 0);
        @(negedge clk);
        checkOutput("validDrop", {23'd0, outValid}, 24'd0, outValid === 1'b0);
    endtask

    // Monitor: every valid output must match the oldest outstanding expectation.
    always @(negedge clk) begin
        expT e;
        bit  ok;
        if (reset === 1'b1 && outValid === 1'b1) begin
            monCount++;
            if (sbQ.size() == 0) begin
                checkOutput("unexpectedOutput", {16'd0, yuvOut}, 24'd0, 1'b0);
            end else begin
                e = sbQ.pop_front();
                if (e.isRgb) begin
                    ok = close(int'(rgbOut[23:16]), int'(e.val[23:16]), e.tol) &&
                         close(int'(rgbOut[15:8]),  int'(e.val[15:8]),  e.tol) &&
                         close(int'(rgbOut[7:0]),   int'(e.val[7:0]),   e.tol);
                    checkOutput("rgbOut", rgbOut, e.val, ok);
                end else begin
                    if (e.sgn)
                        ok = close(toSigned8(yuvOut), toSigned8(e.val[7:0]), e.tol);
                    else
                        ok = close(int'(yuvOut), int'(e.val[7:0]), e.tol);
                    checkOutput("yuvOut", {16'd0, yuvOut}, e.val, ok);
                end
            end
        end
    end

    initial begin
        reset  = 1'b0;
        opMode = 1'b0;
        inEn   = 1'b0;
        rgbIn  = 24'd0;
        yuvIn  = 8'd0;
        repeat (3) @(negedge clk);
        checkOutput("resetBusy",  {23'd0, busy},     24'd0, busy === 1'b0);
        checkOutput("resetValid", {23'd0, outValid}, 24'd0, outValid === 1'b0);
        checkOutput("resetRgb",   rgbOut,            24'd0, rgbOut === 24'd0);
        checkOutput("resetYuv",   {16'd0, yuvOut},   24'd0, yuvOut === 8'd0);
        reset = 1'b1;
        @(negedge clk);

        // Leave an even pixel half-emitted, then reset; the next pixel must be even again.
        applyPixel(24'h123456, 1'b0, 8'd0, 8'd0);
        #2;
        reset = 1'b0;
        inEn  = 1'b0;
        sbQ.delete();
        mPhase = 0;
        gIdx   = 0;
        #1;
        checkOutput("midResetBusy",  {23'd0, busy},     24'd0, busy === 1'b0);
        checkOutput("midResetValid", {23'd0, outValid}, 24'd0, outValid === 1'b0);
        checkOutput("midResetRgb",   rgbOut,            24'd0, rgbOut === 24'd0);
        checkOutput("midResetYuv",   {16'd0, yuvOut},   24'd0, yuvOut === 8'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        applyPixel(24'hFF0000, 1'b1, 8'hD5, 8'h4C);
        applyPixel(24'hFFFFFF, 1'b1, 8'h7F, 8'hFF);
        applyPixel(24'h0000FF, 1'b1, 8'h7F, 8'h1D);
        applyPixel(24'h000000, 1'b1, 8'hEB, 8'h00);
        applyPixel(24'h808080, 1'b1, 8'h00, 8'h80);
        applyPixel(24'h808080, 1'b1, 8'h00, 8'h80);
        drain("r2yDirectedDrain");

        startCount = monCount;
        for (int i = 0; i < 500; i++)
            applyPixel(24'($urandom) & 24'hFFFFFF, 1'b0, 8'd0, 8'd0);
        drain("r2yRandomDrain");
        checkOutput("r2yByteCount", 24'(monCount - startCount), 24'd1000,
                    (monCount - startCount) == 1000);

        applyByte(8'h00, 1'b1, 24'h000000);
        applyByte(8'hFF, 1'b1, 24'h000000);
        applyByte(8'h00, 1'b1, 24'hFFFFFF);
        applyByte(8'h00, 1'b1, 24'h000000);
        applyByte(8'h7F, 1'b1, 24'h000000);
        applyByte(8'h80, 1'b1, 24'h000000);
        applyByte(8'h7F, 1'b1, 24'hFF00FF);
        applyByte(8'h80, 1'b1, 24'hFF00FF);
        for (int i = 0; i < 160; i++)
            applyByte(8'($urandom), 1'b0, 24'd0);
        drain("y2rDrain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cte_color_engine.md
Name: cte_color_engine

Overview:
- Colour Transform Engine that converts between packed 24-bit RGB pixels and 8-bit YUV 4:2:2 byte streams.
- op_mode=1: RGB to YUV. Each pixel pair (P0, P1) produces the bytes U0, Y0, V0, Y1.
- op_mode=0: YUV to RGB. The byte sequence U, Y0, V, Y1 produces two RGB pixels.
- Sits between a pixel source and a downstream consumer, using a simple busy / out_valid handshake.

Parameters:
- FRAC, 12, number of fractional bits in the fixed-point coefficients.

Ports:
- clk  in  1  system clock; all registers update on the rising edge.
- reset  in  1  asynchronous reset, active-low; asserted (0) clears all state.
- op_mode  in  1  1 = RGB to YUV, 0 = YUV to RGB; sampled with each accepted input.
- in_en  in  1  input data valid.
- rgb_in  in  24  RGB pixel: [23:16]=R, [15:8]=G, [7:0]=B, all unsigned.
- yuv_in  in  8  YUV byte: Y unsigned, U/V two's complement.
- busy  out  1  1 = input not accepted this cycle.
- out_valid  out  1  rgb_out or yuv_out is valid this cycle.
- rgb_out  out  24  converted RGB pixel, same packing as rgb_in.
- yuv_out  out  8  converted YUV byte.

Behaviour:
- Reset values: busy=0, out_valid=0, rgb_out=0, yuv_out=0. The pair phase (even/odd pixel or byte index) returns to 0.
- Accept rule: input is accepted at a posedge when in_en=1 and busy=0. When busy=1, in_en and data are ignored; data may be X/Z.
- All outputs are registered.
- RGB to YUV coefficients (scaled by 2^12, signed):
  - Y = 1225R + 2404G + 467B
  - U = -692R - 1356G + 2048B
  - V = 2048R - 1716G - 332B
- YUV to RGB coefficients:
  - R = Y + 5743V
  - G = Y - 1409U - 2925V
  - B = Y + 7258U
  - Y is scaled by 4096 before the sums.
- Rounding: add 2048, arithmetic shift right by 12 (floor).
- Saturation: Y and R/G/B clamp to 0..255; U and V clamp to -128..127 (two's complement on the bus).
- Internal accumulators are at least 22 bits signed.
- RGB to YUV timing: a pixel accepted at posedge k drives busy=1 for exactly one cycle (posedge k to k+1). Bytes appear with out_valid=1 at posedges k+1 and k+2.
  - Even pixel: emits U(of itself), then Y(of itself).
  - Odd pixel: emits V(of the stored even pixel), then Y(of itself).
  - U and V are taken from the even pixel only; no averaging.
  - Back-to-back accepts every 2 cycles give a gap-free byte stream.
  - If no new pixel arrives, out_valid drops after the second byte.
- YUV to RGB timing: busy stays 0; one byte is accepted per cycle.
  - Byte order within a group: U, Y0, V, Y1.
  - One posedge after accepting V: out_valid=1, rgb_out = pixel from (Y0, U, V).
  - One posedge after accepting Y1: out_valid=1, rgb_out = pixel from (Y1, U, V).
  - Other cycles: out_valid=0.
- An op_mode change is honoured only at a pair boundary (phase 0); changing it mid-pair is undefined.
- Reset mid-operation: any partial pair is discarded and the next accepted input is treated as phase 0.
- When in_en=0, the phase holds and no output is produced beyond the pending bytes.

Test Plan:
- Reset low mid-stream, then release -> busy=0, out_valid=0, outputs 0; next pixel is treated as an even pixel.
- RGB to YUV pair FF0000, FFFFFF with in_en held 1 -> busy pattern 1,0,1; yuv_out = D5, 4C, 7F, FF on consecutive cycles (V saturates to 7F).
- RGB to YUV pair 0000FF, 000000 -> bytes 7F, 1D, EB, 00.
- RGB to YUV pair 808080, 808080 -> bytes 00, 80, 00, 80.
- RGB to YUV stream of 500 random pixels with in_en held high -> exactly 1000 bytes, each within ±1 LSB of the floating-point round-to-nearest reference.
- YUV to RGB bytes 00, FF, 00, 00 -> rgb_out FFFFFF, then 000000.
- YUV to RGB bytes 7F, 80, 7F, 80 -> saturating cases: R=FF and B=FF.
